// File: rtl/tag_allocator.sv
// tag_allocator: hands out CDB tags to the dispatcher, takes them back on
// CDB completion, and tracks a single branch checkpoint so that tags handed
// out under a mispredicted branch can be reclaimed in one cycle.
module tag_allocator #(
    parameter int TAG_W   = 7,
    parameter int DEPTH   = 64,
    parameter int NUM_RET = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_req,
    input  logic                       alloc_is_branch,
    output logic                       alloc_gnt,
    output logic [TAG_W-1:0]           alloc_tag,
    output logic                       alloc_avail,
    input  logic [NUM_RET-1:0]         ret_valid,
    input  logic [NUM_RET*TAG_W-1:0]   ret_tag,
    input  logic                       br_resolve,
    input  logic                       br_taken,
    output logic                       flush,
    output logic                       spec_active,
    output logic [$clog2(DEPTH+1)-1:0] free_count,
    output logic                       ret_err
);

    localparam int CW = $clog2(DEPTH + 1);

    // Refuse to build a pool that cannot be named by the tag width, or a
    // pool too small to be useful.
    generate
        if (DEPTH > (2 ** TAG_W) || DEPTH < 2) begin : g_bad_depth
            $error("tag_allocator: DEPTH must lie in 2 .. 2**TAG_W");
        end
    endgenerate

    // The branch checkpoint is a two-state machine: either no unresolved
    // branch is in flight, or exactly one is.
    typedef enum logic {
        CKPT_IDLE = 1'b0,
        CKPT_OPEN = 1'b1
    } ckpt_t;

    ckpt_t            ckpt_q;
    ckpt_t            ckpt_d;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] spec_q;
    logic [DEPTH-1:0] spec_d;
    logic             flush_q;
    logic             flush_d;
    logic             ret_err_q;
    logic             ret_err_d;
    logic [CW-1:0]    free_count_q;
    logic [CW-1:0]    free_count_d;

    logic [TAG_W-1:0] free_tag;
    logic [DEPTH-1:0] free_onehot;

    logic [DEPTH-1:0]   ret_free;
    logic [NUM_RET-1:0] ret_in_range;
    logic               ret_bad;

    logic res_valid;
    logic res_taken;
    logic res_bad;
    logic branch_blocked;

    assign spec_active = (ckpt_q == CKPT_OPEN);
    assign flush       = flush_q;
    assign ret_err     = ret_err_q;
    assign free_count  = free_count_q;

    // Priority-encode the lowest free tag from cycle-start state; scanning
    // downwards lets the lowest index overwrite any higher candidate.
    always_comb begin
        free_tag    = '0;
        free_onehot = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (!busy_q[j]) begin
                free_tag       = TAG_W'(j);
                free_onehot    = '0;
                free_onehot[j] = 1'b1;
            end
        end
    end

    assign alloc_avail = ~&busy_q;
    assign alloc_tag   = free_tag;

    // A resolve only counts when a checkpoint is open; a stray resolve is
    // an error and otherwise has no effect on tag state.
    assign res_valid = br_resolve & spec_active;
    assign res_taken = res_valid & br_taken;
    assign res_bad   = br_resolve & ~spec_active;

    // A second branch waits for the open checkpoint to close. A resolve in
    // the same cycle closes it, so the new branch may take over the
    // checkpoint at that edge (a taken resolve blocks every grant anyway).
    assign branch_blocked = alloc_is_branch & spec_active & ~br_resolve;

    assign alloc_gnt = alloc_req & alloc_avail & ~branch_blocked
                     & ~(br_resolve & br_taken);

    // Decode every CDB return port into a free mask and flag illegal
    // returns: unknown tag, idle tag, or the same tag on two ports.
    always_comb begin
        ret_free     = '0;
        ret_in_range = '0;
        ret_bad      = 1'b0;
        for (int i = 0; i < NUM_RET; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ret_valid[i] && (ret_tag[i*TAG_W +: TAG_W] == TAG_W'(j))) begin
                    ret_in_range[i] = 1'b1;
                    if (busy_q[j]) begin
                        ret_free[j] = 1'b1;
                    end else begin
                        ret_bad = 1'b1;
                    end
                end
            end
            if (ret_valid[i] && !ret_in_range[i]) begin
                ret_bad = 1'b1;
            end
            for (int k = i + 1; k < NUM_RET; k++) begin
                if (ret_valid[i] && ret_valid[k]
                    && (ret_tag[i*TAG_W +: TAG_W] == ret_tag[k*TAG_W +: TAG_W])) begin
                    ret_bad = 1'b1;
                end
            end
        end
    end

    // Combine grant, returns and resolve into the next tag state. A resolve
    // clears spec after the grant is applied, so an instruction dispatched
    // alongside a correctly predicted resolve ends up non-speculative.
    always_comb begin
        busy_d = busy_q;
        spec_d = spec_q;
        if (alloc_gnt) begin
            busy_d = busy_d | free_onehot;
            if (spec_active && !alloc_is_branch) begin
                spec_d = spec_d | free_onehot;
            end
        end
        busy_d = busy_d & ~ret_free;
        spec_d = spec_d & ~ret_free;
        if (res_taken) begin
            busy_d = busy_d & ~spec_q;
        end
        if (res_valid) begin
            spec_d = '0;
        end
        flush_d   = res_taken;
        ret_err_d = ret_err_q | ret_bad | res_bad;
        free_count_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (!busy_d[j]) begin
                free_count_d = free_count_d + CW'(1);
            end
        end
    end

    // Checkpoint next state: open on a granted branch, close on a valid
    // resolve unless a new branch is granted in that same cycle.
    always_comb begin
        ckpt_d = ckpt_q;
        case (ckpt_q)
            CKPT_IDLE: begin
                if (alloc_gnt && alloc_is_branch) begin
                    ckpt_d = CKPT_OPEN;
                end
            end
            CKPT_OPEN: begin
                if (res_valid) begin
                    ckpt_d = (alloc_gnt && alloc_is_branch) ? CKPT_OPEN : CKPT_IDLE;
                end
            end
            default: ckpt_d = CKPT_IDLE;
        endcase
    end

    // State register; reset drops every outstanding tag and the checkpoint
    // without producing a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q       <= '0;
            spec_q       <= '0;
            ckpt_q       <= CKPT_IDLE;
            flush_q      <= 1'b0;
            ret_err_q    <= 1'b0;
            free_count_q <= CW'(DEPTH);
        end else begin
            busy_q       <= busy_d;
            spec_q       <= spec_d;
            ckpt_q       <= ckpt_d;
            flush_q      <= flush_d;
            ret_err_q    <= ret_err_d;
            free_count_q <= free_count_d;
        end
    end

endmodule

// File: tb/tb_tag_allocator.sv
// tb_tag_allocator: directed scenarios followed by constrained-random
// traffic, all checked against a tag-pool model kept in plain arrays.
module tb_tag_allocator;

    localparam int TAG_W   = 4;
    localparam int DEPTH   = 8;
    localparam int NUM_RET = 2;
    localparam int CW      = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     alloc_req;
    logic                     alloc_is_branch;
    logic                     alloc_gnt;
    logic [TAG_W-1:0]         alloc_tag;
    logic                     alloc_avail;
    logic [NUM_RET-1:0]       ret_valid;
    logic [NUM_RET*TAG_W-1:0] ret_tag;
    logic                     br_resolve;
    logic                     br_taken;
    logic                     flush;
    logic                     spec_active;
    logic [CW-1:0]            free_count;
    logic                     ret_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: which tags are outstanding, which were handed out
    // under the open branch, whether a branch is open, and the flags.
    bit m_busy[DEPTH];
    bit m_spec[DEPTH];
    bit m_open;
    bit m_flush;
    bit m_err;

    logic             last_gnt;
    logic [TAG_W-1:0] last_tag;

    always #5 clk = ~clk;

    tag_allocator #(
        .TAG_W   (TAG_W),
        .DEPTH   (DEPTH),
        .NUM_RET (NUM_RET)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_is_branch (alloc_is_branch),
        .alloc_gnt       (alloc_gnt),
        .alloc_tag       (alloc_tag),
        .alloc_avail     (alloc_avail),
        .ret_valid       (ret_valid),
        .ret_tag         (ret_tag),
        .br_resolve      (br_resolve),
        .br_taken        (br_taken),
        .flush           (flush),
        .spec_active     (spec_active),
        .free_count      (free_count),
        .ret_err         (ret_err)
    );

    function automatic int modelFree();
        int n = 0;
        for (int t = 0; t < DEPTH; t++) if (!m_busy[t]) n++;
        return n;
    endfunction

    function automatic int modelLowest();
        for (int t = 0; t < DEPTH; t++) if (!m_busy[t]) return t;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational grant path,
    // advance the model across the edge, then check the registered outputs.
    task automatic applyStimulus(input bit rstn, input bit req, input bit is_br,
                                 input bit [1:0] rv, input int t0, input int t1,
                                 input bit bres, input bit btaken);
        bit exp_avail;
        bit exp_gnt;
        int lo;
        int tags[2];
        bit nb[DEPTH];
        bit ns[DEPTH];
        rst             = rstn;
        alloc_req       = req;
        alloc_is_branch = is_br;
        ret_valid       = rv;
        ret_tag         = {t1[TAG_W-1:0], t0[TAG_W-1:0]};
        br_resolve      = bres;
        br_taken        = btaken;
        #1;
        exp_avail = (modelFree() != 0);
        lo        = exp_avail ? modelLowest() : 0;
        exp_gnt   = req && exp_avail && !(is_br && m_open && !bres) && !(bres && btaken);
        checkOutput("alloc_avail", alloc_avail, exp_avail);
        checkOutput("alloc_tag", alloc_tag, lo);
        checkOutput("alloc_gnt", alloc_gnt, exp_gnt);
        last_gnt = alloc_gnt;
        last_tag = alloc_tag;
        @(posedge clk);
        if (!rstn) begin
            for (int t = 0; t < DEPTH; t++) begin
                m_busy[t] = 0;
                m_spec[t] = 0;
            end
            m_open  = 0;
            m_flush = 0;
            m_err   = 0;
        end else begin
            nb = m_busy;
            ns = m_spec;
            if (exp_gnt) begin
                nb[lo] = 1;
                ns[lo] = m_open && !is_br;
            end
            tags[0] = t0;
            tags[1] = t1;
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) begin
                    if (tags[p] >= DEPTH || !m_busy[tags[p]]) begin
                        m_err = 1;
                    end else begin
                        nb[tags[p]] = 0;
                        ns[tags[p]] = 0;
                    end
                end
            end
            if (rv == 2'b11 && t0 == t1) m_err = 1;
            if (bres && !m_open) m_err = 1;
            m_flush = bres && m_open && btaken;
            if (bres && m_open) begin
                for (int t = 0; t < DEPTH; t++) begin
                    if (btaken && m_spec[t]) nb[t] = 0;
                    ns[t] = 0;
                end
                m_open = 0;
            end
            if (exp_gnt && is_br) m_open = 1;
            m_busy = nb;
            m_spec = ns;
        end
        #1;
        checkOutput("flush", flush, m_flush);
        checkOutput("spec_active", spec_active, m_open);
        checkOutput("free_count", free_count, modelFree());
        checkOutput("ret_err", ret_err, m_err);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    int  r_t[2];
    bit  r_rstn, r_req, r_br, r_bres, r_taken;
    bit [1:0] r_rv;
    int  start;

    initial begin
        rst = 1'b0; alloc_req = 1'b0; alloc_is_branch = 1'b0; ret_valid = '0;
        ret_tag = '0; br_resolve = 1'b0; br_taken = 1'b0;
        for (int t = 0; t < DEPTH; t++) begin
            m_busy[t] = 0;
            m_spec[t] = 0;
        end
        m_open = 0; m_flush = 0; m_err = 0;
        @(posedge clk);
        @(negedge clk);
        $display("[TB] reset and fill");
        doReset();
        checkOutput("reset_free", free_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
            checkOutput("fill_tag", last_tag, i);
            checkOutput("fill_free", free_count, DEPTH - 1 - i);
        end
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("full_gnt", last_gnt, 0);
        checkOutput("full_avail", alloc_avail, 0);

        $display("[TB] dual return");
        applyStimulus(1, 0, 0, 2'b11, 3, 5, 0, 0);
        checkOutput("ret2_free", free_count, 2);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("realloc_3", last_tag, 3);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("realloc_5", last_tag, 5);

        $display("[TB] freed tag not reusable in same cycle");
        applyStimulus(1, 1, 0, 2'b01, 2, 0, 0, 0);
        checkOutput("same_cycle_gnt", last_gnt, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("next_cycle_tag", last_tag, 2);

        $display("[TB] taken branch");
        doReset();
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 0, 0);
        checkOutput("br_open", spec_active, 1);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 1);
        checkOutput("taken_free", free_count, 7);
        checkOutput("taken_flush", flush, 1);
        checkOutput("taken_spec", spec_active, 0);
        idle();
        checkOutput("flush_one_cycle", flush, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("after_flush_tag", last_tag, 1);

        $display("[TB] not-taken branch");
        doReset();
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 0, 0);
        checkOutput("second_branch_gnt", last_gnt, 0);
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0);
        checkOutput("nt_free", free_count, 5);
        checkOutput("nt_flush", flush, 0);
        checkOutput("nt_spec", spec_active, 0);

        $display("[TB] branch alloc with resolve");
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 1, 0);
        checkOutput("handover_gnt", last_gnt, 1);
        checkOutput("handover_spec", spec_active, 1);
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 1);
        checkOutput("handover_flush_free", free_count, 3);

        $display("[TB] return errors");
        doReset();
        applyStimulus(1, 0, 0, 2'b01, 6, 0, 0, 0);
        checkOutput("idle_ret_err", ret_err, 1);
        checkOutput("idle_ret_free", free_count, DEPTH);
        idle();
        checkOutput("err_sticky", ret_err, 1);
        doReset();
        checkOutput("err_cleared", ret_err, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b11, 0, 0, 0, 0);
        checkOutput("dup_err", ret_err, 1);
        checkOutput("dup_free", free_count, DEPTH);
        doReset();
        applyStimulus(1, 0, 0, 2'b10, 0, 9, 0, 0);
        checkOutput("range_err", ret_err, 1);
        doReset();
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0);
        checkOutput("stray_resolve_err", ret_err, 1);

        $display("[TB] reset mid-checkpoint");
        doReset();
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 1, 1);
        checkOutput("rst_free", free_count, DEPTH);
        checkOutput("rst_spec", spec_active, 0);
        checkOutput("rst_flush", flush, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            r_rstn  = ($urandom_range(0, 59) != 0);
            r_req   = ($urandom_range(0, 9) < 6);
            r_br    = ($urandom_range(0, 4) == 0);
            r_rv    = '0;
            for (int p = 0; p < 2; p++) begin
                r_t[p] = 0;
                if ($urandom_range(0, 9) < 3) begin
                    r_rv[p] = 1'b1;
                    if ($urandom_range(0, 29) == 0) begin
                        r_t[p] = $urandom_range(0, 15);
                    end else begin
                        start  = $urandom_range(0, DEPTH - 1);
                        r_t[p] = start;
                        for (int k = 0; k < DEPTH; k++) begin
                            if (m_busy[(start + k) % DEPTH]) begin
                                r_t[p] = (start + k) % DEPTH;
                                break;
                            end
                        end
                    end
                end
            end
            r_bres  = m_open ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            r_taken = $urandom_range(0, 1);
            applyStimulus(r_rstn, r_req, r_br, r_rv, r_t[0], r_t[1], r_bres, r_taken);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
